// File: rtl/vram_arbiter.sv
// Text VRAM arbiter: display fetches own the slot cycles, the char writer gets the rest.
// Define VRAM_CLEAR_EN to add the FILL_CHAR screen-clear engine (clr_start / clr_busy).
module vram_arbiter #(
  parameter int unsigned COLS    = 80,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525
`ifdef VRAM_CLEAR_EN
  ,
  parameter logic [7:0]  FILL_CHAR = 8'h20
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        char_code,
  output logic              char_valid
`ifdef VRAM_CLEAR_EN
  ,
  input  logic              clr_start,
  output logic              clr_busy
`endif
);

  localparam logic [ADDR_W-1:0] CELLS  = ADDR_W'(COLS * ROWS);
  localparam logic [9:0]        H_LAST = 10'(H_TOTAL);
  localparam logic [9:0]        V_LAST = 10'(V_TOTAL);
  localparam logic [9:0]        X_VIS  = 10'd639;
  localparam logic [9:0]        Y_VIS  = 10'd480;
`ifdef VRAM_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    WRITE
`ifdef VRAM_CLEAR_EN
    ,
    CLEAR
`endif
  } state_t;

  state_t            state;
  logic              fetch_d;
  logic [9:0]        next_y;
  logic [9:0]        slot_row;
  logic [9:0]        slot_col;
  logic              in_line;
  logic              at_wrap;
  logic              slot;
  logic [ADDR_W-1:0] row_a;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] slot_addr;
`ifdef VRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_ptr;
`endif

  // Slot detection: the address for the column the beam enters next cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    next_y   = (counter_y == V_LAST) ? 10'd0 : counter_y + 10'd1;
    in_line  = (counter_x[2:0] == 3'd7) && (counter_x < X_VIS) && (counter_y < Y_VIS);
    at_wrap  = (counter_x == H_LAST) && (next_y < Y_VIS);
    slot     = in_line || at_wrap;
    slot_col = 10'd0;
    slot_row = next_y >> 4;
    if (in_line) begin
      slot_col = (counter_x >> 3) + 10'd1;
      slot_row = counter_y >> 4;
    end
  end

  assign row_a = ADDR_W'(slot_row);

  if (COLS == 80) begin : g_mul80
    assign row_base = (row_a << 6) + (row_a << 4);
  end else begin : g_mul
    assign row_base = row_a * ADDR_W'(COLS);
  end

  assign slot_addr = row_base + ADDR_W'(slot_col);

  always_ff @(posedge clk) begin
    // NOTE: state and all outputs are registers, so only non-blocking assignments here.
    if (reset) begin
      state      <= IDLE;
      fetch_d    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      wr_ack     <= 1'b0;
      char_code  <= '0;
      char_valid <= 1'b0;
`ifdef VRAM_CLEAR_EN
      clr_busy   <= 1'b0;
      clr_ptr    <= '0;
`endif
    end else begin
      mem_we     <= 1'b0;
      wr_ack     <= 1'b0;
      fetch_d    <= slot;
      char_valid <= fetch_d;
      if (fetch_d) char_code <= mem_rdata;
      if (slot) mem_addr <= slot_addr;

      case (state)
        IDLE: begin
`ifdef VRAM_CLEAR_EN
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_ptr  <= '0;
          end else
`endif
          if (wr_req && !slot) begin
            state     <= WRITE;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            mem_we    <= (wr_addr < CELLS);
            wr_ack    <= 1'b1;
          end
        end
        // Recovery cycle: a stale wr_req seen here is never double-written.
        WRITE: state <= IDLE;
`ifdef VRAM_CLEAR_EN
        CLEAR: begin
          if (!slot) begin
            mem_addr  <= clr_ptr;
            mem_wdata <= FILL_CHAR;
            mem_we    <= 1'b1;
            if (clr_ptr == LAST_CELL) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
              clr_ptr  <= '0;
            end else begin
              clr_ptr <= clr_ptr + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed corner cases plus randomized traffic
// scored against a pixel-position reference model and a shadow copy of the RAM.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  counter_x;
  logic [9:0]  counter_y;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  char_code;
  logic        char_valid;
`ifdef VRAM_CLEAR_EN
  logic        clr_start;
  logic        clr_busy;
`endif

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .counter_x  (counter_x),
    .counter_y  (counter_y),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .char_code  (char_code),
    .char_valid (char_valid)
`ifdef VRAM_CLEAR_EN
    ,
    .clr_start  (clr_start),
    .clr_busy   (clr_busy)
`endif
  );

  // Bench-side RAM: combinational read, write on the clock edge; pl_* preloads cells.
  logic [7:0]  vram [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;

  assign mem_rdata = vram[mem_addr];

  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    if (pl_en) vram[pl_addr] <= pl_data;
  end

  // Reference model state.
  logic [7:0] ref_ram [0:4095];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         m_cool;
  bit         m_pend;
  bit         m_land;
  int         m_pend_addr;
  int         m_land_addr;
  logic [7:0] m_land_data;
  logic [7:0] m_char;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock with counters (x,y); expectations come from the next beam position.
  task automatic tick(input int x, input int y);
    int         nx;
    int         ny;
    int         faddr;
    bit         fetch;
    bit         accept;
    bit         exp_cv;
    logic [7:0] exp_cc;
    counter_x = 10'(x);
    counter_y = 10'(y);
    if (x == 800) begin
      nx = 0;
      ny = (y == 525) ? 0 : y + 1;
    end else begin
      nx = x + 1;
      ny = y;
    end
    fetch  = (nx < 640) && (nx % 8 == 0) && (ny < 480);
    faddr  = (ny / 16) * 80 + nx / 8;
    accept = !reset && !m_cool && wr_req && !fetch;
    @(posedge clk);
    #1;
    exp_cv = m_pend;
    exp_cc = m_pend ? ref_ram[m_pend_addr] : m_char;
    if (m_land) ref_ram[m_land_addr] = m_land_data;
    m_land = 1'b0;
    if (reset) begin
      check("rst_char_valid", 32'(char_valid), 32'(0));
      check("rst_char_code",  32'(char_code),  32'(0));
      check("rst_mem_we",     32'(mem_we),     32'(0));
      check("rst_wr_ack",     32'(wr_ack),     32'(0));
      check("rst_mem_addr",   32'(mem_addr),   32'(0));
      check("rst_mem_wdata",  32'(mem_wdata),  32'(0));
      m_cool = 1'b0;
      m_pend = 1'b0;
      m_char = 8'h00;
    end else begin
      check("char_valid", 32'(char_valid), 32'(exp_cv));
      check("char_code",  32'(char_code),  32'(exp_cc));
      check("wr_ack",     32'(wr_ack),     32'(accept));
      check("mem_we",     32'(mem_we),     32'(accept && (wr_addr < 2400)));
      if (fetch) check("fetch_addr", 32'(mem_addr), 32'(faddr));
      if (accept) begin
        check("write_addr", 32'(mem_addr),  32'(wr_addr));
        check("write_data", 32'(mem_wdata), 32'(wr_data));
      end
      m_char      = exp_cc;
      m_cool      = accept;
      m_pend      = fetch;
      m_pend_addr = faddr;
      m_land      = accept && (wr_addr < 2400);
      m_land_addr = int'(wr_addr);
      m_land_data = wr_data;
    end
  endtask

  task automatic advance(inout int x, inout int y);
    if (x == 800) begin
      x = 0;
      y = (y == 525) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
  endtask

  task automatic new_req();
    wr_req  = 1'b1;
    wr_addr = 12'($urandom_range(0, 2599));
    wr_data = 8'($urandom);
  endtask

  initial begin
    int x;
    int y;
    int bad;
    reset     = 1'b1;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    counter_x = '0;
    counter_y = '0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = '0;
`ifdef VRAM_CLEAR_EN
    clr_start = 1'b0;
`endif
    m_cool = 1'b0;
    m_pend = 1'b0;
    m_land = 1'b0;
    m_char = 8'h00;

    // Preload RAM while the DUT is held in reset; cell 2400 is an out-of-range sentinel.
    for (int i = 0; i <= 2400; i++) begin
      pl_en   = 1'b1;
      pl_addr = 12'(i);
      pl_data = (i == 81) ? 8'h41 : (i == 2400) ? 8'hEE : 8'($urandom);
      ref_ram[i] = pl_data;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    tick(5, 0);
    reset = 1'b0;

    // Fetch timing.
    tick(6, 16);
    tick(7, 16);
    check("fetch81_addr", 32'(mem_addr), 32'(81));
    check("fetch81_we",   32'(mem_we),   32'(0));
    tick(8, 16);
    check("fetch81_char",  32'(char_code),  32'(8'h41));
    check("fetch81_valid", 32'(char_valid), 32'(1));

    // Write colliding with a slot is deferred by one cycle.
    wr_req  = 1'b1;
    wr_addr = 12'd500;
    wr_data = 8'h5A;
    tick(7, 32);
    check("coll_we_slot",  32'(mem_we), 32'(0));
    check("coll_ack_slot", 32'(wr_ack), 32'(0));
    tick(8, 32);
    check("coll_we",   32'(mem_we),    32'(1));
    check("coll_addr", 32'(mem_addr),  32'(500));
    check("coll_data", 32'(mem_wdata), 32'(8'h5A));
    check("coll_ack",  32'(wr_ack),    32'(1));
    wr_req = 1'b0;
    tick(9, 32);

    // Out-of-range write is acked but dropped.
    wr_req  = 1'b1;
    wr_addr = 12'd2400;
    wr_data = 8'h99;
    tick(10, 32);
    check("oor_ack", 32'(wr_ack), 32'(1));
    check("oor_we",  32'(mem_we), 32'(0));
    wr_req = 1'b0;
    tick(11, 32);
    tick(12, 32);
    check("oor_ram",  32'(vram[2400]), 32'(8'hEE));
    check("coll_ram", 32'(vram[500]),  32'(8'h5A));

    // Line wrap fetches.
    tick(800, 15);
    check("wrap_addr", 32'(mem_addr), 32'(80));
    tick(0, 16);
    check("wrap_valid", 32'(char_valid), 32'(1));
    tick(800, 479);
    tick(0, 480);
    check("wrap_nofetch", 32'(char_valid), 32'(0));

    // Reset during the write cycle.
    wr_req  = 1'b1;
    wr_addr = 12'd700;
    wr_data = 8'h3C;
    tick(20, 100);
    check("rmw_ack", 32'(wr_ack), 32'(1));
    reset = 1'b1;
    tick(21, 100);
    reset  = 1'b0;
    wr_req = 1'b0;
    tick(22, 100);
    check("rmw_no_ack", 32'(wr_ack), 32'(0));
    check("rmw_no_we",  32'(mem_we), 32'(0));

    // Randomized traffic over free-running counters.
    for (int seg = 0; seg < 4; seg++) begin
      x = $urandom_range(0, 800);
      y = (seg == 0) ? 478 : (seg == 1) ? 524 : $urandom_range(0, 525);
      for (int c = 0; c < 1500; c++) begin
        tick(x, y);
        if (wr_ack) begin
          wr_req = 1'b0;
          if ($urandom_range(0, 1) == 1) new_req();
        end else if (wr_req) begin
          if ($urandom_range(0, 15) == 0) wr_req = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_req();
        end
        advance(x, y);
      end
    end
    wr_req = 1'b0;
    tick(x, y);
    advance(x, y);
    tick(x, y);
    advance(x, y);

    bad = 0;
    for (int i = 0; i <= 2400; i++) if (vram[i] !== ref_ram[i]) bad++;
    check("ram_contents", 32'(bad), 32'(0));

`ifdef VRAM_CLEAR_EN
    begin : clear_test
      bit fell;
      bit acked;
      bit early;
      clr_start = 1'b1;
      counter_x = 10'(x);
      counter_y = 10'(y);
      @(posedge clk);
      #1;
      advance(x, y);
      clr_start = 1'b0;
      check("clr_busy_set", 32'(clr_busy), 32'(1));
      wr_req  = 1'b1;
      wr_addr = 12'd10;
      wr_data = 8'h77;
      fell  = 1'b0;
      acked = 1'b0;
      early = 1'b0;
      for (int c = 0; c < 8000 && !(fell && acked); c++) begin
        counter_x = 10'(x);
        counter_y = 10'(y);
        @(posedge clk);
        #1;
        advance(x, y);
        if (wr_ack) begin
          acked = 1'b1;
          if (!fell) early = 1'b1;
          wr_req = 1'b0;
        end
        if (!clr_busy) fell = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
        counter_x = 10'(x);
        counter_y = 10'(y);
        @(posedge clk);
        #1;
        advance(x, y);
      end
      check("clr_done",     32'(fell),  32'(1));
      check("clr_wr_acked", 32'(acked), 32'(1));
      check("clr_no_early", 32'(early), 32'(0));
      bad = 0;
      for (int i = 0; i < 2400; i++) if (i != 10 && vram[i] !== 8'h20) bad++;
      check("clr_fill",   32'(bad),      32'(0));
      check("clr_wr_val", 32'(vram[10]), 32'(8'h77));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
